// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Control block between the board buttons/switches and an 8-bit ALU plus a
// seven-segment driver. Debounces four operation buttons, accepts exactly one
// operation at a time, snapshots the operands, runs a start/done handshake
// with the ALU, then shows the operands and the result for one timed phase each.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   btn[3:0]        raw buttons: [0]=add [1]=sub [2]=shl A [3]=compare
//   sw_a, sw_b      operand switches
//   alu_start       one-cycle start pulse to the ALU
//   alu_op          00 add, 01 sub, 10 shl, 11 cmp
//   alu_a, alu_b    operands latched when the operation is accepted
//   alu_done        ALU result valid (single-cycle pulse)
//   alu_result      ALU result
//   alu_flags       {eq, brw, ovf}, valid with alu_done
//   disp_word       word for the seven-segment driver
//   disp_en         display enable (0 blanks all digits)
//   flags           latched {eq, brw, ovf}
//   busy            high in every state except idle
//   err             one-cycle pulse on multi-button press or ALU timeout
module alu_op_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned PHASE_CYCLES    = 200_000_000,
    parameter int unsigned DONE_TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic [7:0]  sw_a,
    input  logic [7:0]  sw_b,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic [15:0] disp_word,
    output logic        disp_en,
    output logic [2:0]  flags,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PhW = $clog2(PHASE_CYCLES + 1);
    localparam int unsigned ToW = $clog2(DONE_TIMEOUT + 1);

    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PhW-1:0] PhLast = PhW'(PHASE_CYCLES - 1);
    localparam logic [PhW-1:0] PhMax  = PhW'(PHASE_CYCLES);
    localparam logic [ToW-1:0] ToLast = ToW'(DONE_TIMEOUT - 1);
    localparam logic [ToW-1:0] ToMax  = ToW'(DONE_TIMEOUT);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StShowOp, StShowRes} state_e;

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers
    // ------------------------------------------------------------------
    logic [3:0]     sync1_q, sync2_q;
    logic [1:0]     valid_q;
    logic [3:0]     deb_q, deb_d;
    logic [3:0]     press_q, press_d;
    logic [3:0]     arm_q, arm_d;
    logic [DbW-1:0] db_cnt_q [4];
    logic [DbW-1:0] db_cnt_d [4];

    // valid_q marks when sync2_q holds a real post-reset sample. A button is
    // only armed once it has been seen released, so a button held through
    // reset cannot fire until it is released and pressed again.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            deb_d[i]    = deb_q[i];
            press_d[i]  = 1'b0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i] & arm_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            arm_d[i] = arm_q[i] | (valid_q[1] & ~sync2_q[i] & ~deb_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            valid_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            arm_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            valid_q <= {valid_q[0], 1'b1};
            deb_q   <= deb_d;
            press_q <= press_d;
            arm_q   <= arm_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    logic       press_any;
    logic       deb_onehot;
    logic [1:0] op_sel;

    assign press_any  = |press_q;
    assign deb_onehot = (deb_q != 4'b0) && ((deb_q & (deb_q - 4'd1)) == 4'b0);

    always_comb begin
        op_sel = 2'd0;
        case (deb_q)
            4'b0010: op_sel = 2'd1;
            4'b0100: op_sel = 2'd2;
            4'b1000: op_sel = 2'd3;
            default: op_sel = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [PhW-1:0] ph_cnt_q, ph_cnt_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]    result_q, result_d;
    logic           accept, reject, take_done, time_out;

    logic           alu_start_q, alu_start_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic [7:0]     alu_a_q, alu_a_d;
    logic [7:0]     alu_b_q, alu_b_d;
    logic [15:0]    disp_word_q, disp_word_d;
    logic           disp_en_q, disp_en_d;
    logic [2:0]     flags_q, flags_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ph_cnt_q    <= '0;
            to_cnt_q    <= '0;
            result_q    <= '0;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            disp_word_q <= '0;
            disp_en_q   <= 1'b0;
            flags_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            to_cnt_q    <= to_cnt_d;
            result_q    <= result_d;
            alu_start_q <= alu_start_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            disp_word_q <= disp_word_d;
            disp_en_q   <= disp_en_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Next state. Press events are only looked at in idle, so an event that
    // coincides with a phase end is dropped.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        take_done = 1'b0;
        time_out  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press_any) begin
                    if (deb_onehot) begin
                        accept  = 1'b1;
                        state_d = StIssue;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // done takes priority over a timeout expiring in the same cycle
                if (alu_done) begin
                    take_done = 1'b1;
                    state_d   = StShowOp;
                end else if (to_cnt_q == ToLast) begin
                    time_out = 1'b1;
                    state_d  = StIdle;
                end
            end
            StShowOp: begin
                if (ph_cnt_q == PhLast) begin
                    state_d = StShowRes;
                end
            end
            StShowRes: begin
                if (ph_cnt_q == PhLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values, decoded from the next state so every
    // output is a plain register.
    always_comb begin
        alu_start_d = (state_d == StIssue);
        busy_d      = (state_d != StIdle);
        disp_en_d   = (state_d == StShowOp) || (state_d == StShowRes);
        disp_word_d = '0;
        if (state_d == StShowOp) begin
            disp_word_d = {alu_b_q, alu_a_q};
        end else if (state_d == StShowRes) begin
            disp_word_d = result_q;
        end
        err_d = reject | time_out;

        alu_op_d = accept ? op_sel : alu_op_q;
        alu_a_d  = accept ? sw_a : alu_a_q;
        alu_b_d  = accept ? sw_b : alu_b_q;
        result_d = take_done ? alu_result : result_q;

        flags_d = flags_q;
        if (accept) begin
            flags_d = '0;
        end else if (take_done) begin
            flags_d = alu_flags;
        end

        // Counters restart on every state entry and saturate instead of wrapping
        ph_cnt_d = ph_cnt_q;
        if (state_d != state_q) begin
            ph_cnt_d = '0;
        end else if (ph_cnt_q != PhMax) begin
            ph_cnt_d = ph_cnt_q + 1'b1;
        end

        to_cnt_d = to_cnt_q;
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != ToMax) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign alu_start = alu_start_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign disp_word = disp_word_q;
    assign disp_en   = disp_en_q;
    assign flags     = flags_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with small timing parameters.
// Expected behaviour is derived from press/done offsets with plain arithmetic.
module tb_alu_op_sequencer;

    localparam int unsigned DB = 4;
    localparam int unsigned PH = 8;
    localparam int unsigned TO = 16;
    localparam int S = DB + 3;  // press offset to alu_start

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = '0;
    logic [7:0]  sw_a = '0;
    logic [7:0]  sw_b = '0;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic [2:0]  alu_flags = '0;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] disp_word;
    logic        disp_en;
    logic [2:0]  flags;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int alu_lat = 2;  // 0 = ALU never answers
    int cd = 0;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b;
    logic [2:0] prev_flags = '0;

    alu_op_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .PHASE_CYCLES   (PH),
        .DONE_TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .sw_a      (sw_a),
        .sw_b      (sw_b),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_done  (alu_done),
        .alu_result(alu_result),
        .alu_flags (alu_flags),
        .disp_word (disp_word),
        .disp_en   (disp_en),
        .flags     (flags),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] alu_fn(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] r;
        logic [2:0]  f;
        case (op)
            2'd0:    r = {8'h00, a} + {8'h00, b};
            2'd1:    r = {8'h00, a} - {8'h00, b};
            2'd2:    r = {7'h00, a, 1'b0};
            default: r = {15'h0000, (a > b)};
        endcase
        f = {(a == b), (a < b), (({1'b0, a} + {1'b0, b}) > 9'd255)};
        return {f, r};
    endfunction

    // ALU model and event counters; alu_done is driven for the cycle it is set in
    always @(negedge clk) begin
        if (alu_start) start_cnt = start_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        alu_done = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                {alu_flags, alu_result} = alu_fn(m_op, m_a, m_b);
                alu_done = 1'b1;
            end
        end
        if (alu_start && alu_lat > 0) begin
            cd   = alu_lat;
            m_op = alu_op;
            m_a  = alu_a;
            m_b  = alu_b;
        end
        if (rst) cd = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        btn = '0;
        repeat (DB + 8) tick();
    endtask

    // Presses mask at offset 0 and checks every cycle of the whole sequence.
    task automatic run_seq(input logic [3:0] mask, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input int lat, input int inject_at);
        logic [18:0] fr;
        logic [15:0] res, ew;
        logic [2:0]  fl, ef;
        logic        es, eb, ee;
        logic [22:0] obs, exp;
        int d, ob, rb, idl;
        fr  = alu_fn(op, a, b);
        res = fr[15:0];
        fl  = fr[18:16];
        d   = S + lat;
        ob  = d + 1;
        rb  = ob + PH;
        idl = rb + PH;
        alu_lat = lat;
        sw_a = a;
        sw_b = b;
        btn  = mask;
        for (int o = 0; o <= idl + 3; o++) begin
            if (o == inject_at) btn = btn | 4'b1000;
            es = (o == S);
            eb = (o >= S) && (o < idl);
            ee = (o >= ob) && (o < idl);
            if (o >= ob && o < rb) ew = {b, a};
            else if (o >= rb && o < idl) ew = res;
            else ew = 16'h0000;
            if (o < S) ef = prev_flags;
            else if (o < ob) ef = 3'b000;
            else ef = fl;
            exp = {es, eb, ee, 1'b0, ew, ef};
            obs = {alu_start, busy, disp_en, err, disp_word, flags};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL seq op%0d off%0d: got st/bz/en/er=%b%b%b%b word=%h fl=%b, want %b%b%b0 word=%h fl=%b",
                         op, o, alu_start, busy, disp_en, err, disp_word, flags,
                         es, eb, ee, ew, ef);
            end
            if (o >= S && o < idl) begin
                checks++;
                if ({alu_op, alu_a, alu_b} !== {op, a, b}) begin
                    failures++;
                    $display("FAIL operands off%0d: got op=%0d a=%h b=%h, want op=%0d a=%h b=%h",
                             o, alu_op, alu_a, alu_b, op, a, b);
                end
            end
            tick();
        end
        prev_flags = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = '0;
        repeat (3) tick();
        checks++;
        if ({alu_start, alu_op, alu_a, alu_b, disp_word, disp_en, flags, busy, err} !== '0) begin
            failures++;
            $display("FAIL reset: got st=%b op=%b a=%h b=%h w=%h en=%b fl=%b bz=%b er=%b, want all 0",
                     alu_start, alu_op, alu_a, alu_b, disp_word, disp_en, flags, busy, err);
        end
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if ({alu_start, busy, disp_en, err} !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_idle: got st/bz/en/er=%b%b%b%b, want 0000",
                     alu_start, busy, disp_en, err);
        end
    endtask

    task automatic test_add();
        run_seq(4'b0001, 2'd0, 8'h3C, 8'h05, 2, -1);
        release_all();
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [3:0] m;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            m  = 4'b0001 << op;
            run_seq(m, op, 8'($urandom), 8'($urandom), int'($urandom_range(1, 6)), -1);
            release_all();
        end
    endtask

    task automatic test_done_at_timeout();
        run_seq(4'b0010, 2'd1, 8'($urandom), 8'($urandom), TO, -1);
        release_all();
    endtask

    task automatic test_bounce();
        int base;
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        sw_a = a;
        sw_b = b;
        base = start_cnt;
        for (int o = 0; o < 20; o++) begin
            btn = (((o / 2) % 2) == 0) ? 4'b0010 : 4'b0000;
            tick();
        end
        checks++;
        if (start_cnt != base) begin
            failures++;
            $display("FAIL bounce_no_start: got %0d starts, want 0", start_cnt - base);
        end
        run_seq(4'b0010, 2'd1, a, b, 2, -1);
        checks++;
        if (start_cnt != base + 1) begin
            failures++;
            $display("FAIL bounce_one_start: got %0d starts, want 1", start_cnt - base);
        end
        release_all();
    endtask

    task automatic test_multi();
        int be, bs;
        logic [2:0] exp;
        be = err_cnt;
        bs = start_cnt;
        btn = 4'b0011;
        for (int o = 0; o < 16; o++) begin
            exp = {1'b0, 1'b0, (o == S)};
            checks++;
            if ({alu_start, busy, err} !== exp) begin
                failures++;
                $display("FAIL multi off%0d: got st/bz/er=%b%b%b, want %b",
                         o, alu_start, busy, err, exp);
            end
            tick();
        end
        checks++;
        if (err_cnt != be + 1 || start_cnt != bs) begin
            failures++;
            $display("FAIL multi_counts: got err=%0d start=%0d, want err=1 start=0",
                     err_cnt - be, start_cnt - bs);
        end
        release_all();
    endtask

    task automatic test_lockout();
        int base;
        run_seq(4'b0100, 2'd2, 8'($urandom), 8'($urandom), 2, S + 2 + 1 + 2);
        base = start_cnt;
        repeat (20) tick();
        checks++;
        if (start_cnt != base || busy !== 1'b0) begin
            failures++;
            $display("FAIL lockout_held: got %0d starts busy=%b, want 0 starts busy=0",
                     start_cnt - base, busy);
        end
        release_all();
        run_seq(4'b1000, 2'd3, 8'($urandom), 8'($urandom), 2, -1);
        release_all();
    endtask

    task automatic test_timeout();
        int be;
        logic [3:0] exp;
        be = err_cnt;
        alu_lat = 0;
        sw_a = 8'($urandom);
        sw_b = 8'($urandom);
        btn = 4'b0010;
        for (int o = 0; o <= 30; o++) begin
            exp = {(o == S), (o >= S && o < S + 1 + int'(TO)), 1'b0, (o == S + 1 + int'(TO))};
            checks++;
            if ({alu_start, busy, disp_en, err} !== exp) begin
                failures++;
                $display("FAIL timeout off%0d: got st/bz/en/er=%b%b%b%b, want %b",
                         o, alu_start, busy, disp_en, err, exp);
            end
            if (o == S + 1 + int'(TO)) begin
                checks++;
                if (flags !== 3'b000) begin
                    failures++;
                    $display("FAIL timeout_flags: got %b, want 000", flags);
                end
            end
            tick();
        end
        checks++;
        if (err_cnt != be + 1) begin
            failures++;
            $display("FAIL timeout_err_count: got %0d, want 1", err_cnt - be);
        end
        alu_lat = 2;
        prev_flags = 3'b000;
        release_all();
    endtask

    task automatic test_reset_mid();
        int base;
        alu_lat = 2;
        sw_a = 8'($urandom);
        sw_b = 8'($urandom);
        btn = 4'b0001;
        repeat (S + 2 + 1 + PH + 3) tick();
        checks++;
        if (disp_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: got en=%b bz=%b, want 1 1", disp_en, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_start, alu_op, alu_a, alu_b, disp_word, disp_en, flags, busy, err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_zero: got st=%b op=%b a=%h b=%h w=%h en=%b fl=%b bz=%b er=%b",
                     alu_start, alu_op, alu_a, alu_b, disp_word, disp_en, flags, busy, err);
        end
        repeat (2) tick();
        rst = 1'b0;
        prev_flags = 3'b000;
        base = start_cnt;
        repeat (30) tick();
        checks++;
        if (start_cnt != base || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_btn: got %0d starts busy=%b, want 0 starts busy=0",
                     start_cnt - base, busy);
        end
        release_all();
        run_seq(4'b0001, 2'd0, 8'($urandom), 8'($urandom), 3, -1);
        release_all();
    endtask

    initial begin
        test_reset();
        test_add();
        test_random();
        test_done_at_timeout();
        test_bounce();
        test_multi();
        test_lockout();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control block that sits between the board buttons/switches and the 8-bit ALU datapath and seven-segment driver. It debounces the four operation buttons and accepts exactly one operation at a time. It snapshots the operands, issues a start/done handshake to the ALU, and then sequences the display through a timed operand phase and a timed result phase. Flags are latched from the ALU for the status LEDs.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a button level is accepted
- PHASE_CYCLES, 200_000_000, duration in clk cycles of each display phase
- DONE_TIMEOUT, 16, max cycles waited for alu_done after start
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn  in  4  raw buttons; [0]=add, [1]=sub, [2]=shift-left A, [3]=compare
- sw_a  in  8  operand A switches
- sw_b  in  8  operand B switches
- alu_start  out  1  one-cycle start pulse to ALU
- alu_op  out  2  operation code: 00 add, 01 sub, 10 shl, 11 cmp
- alu_a, alu_b  out  8 each  latched operands, stable from start until IDLE
- alu_done  in  1  ALU result valid, single-cycle pulse
- alu_result  in  16  ALU result
- alu_flags  in  3  {eq, brw, ovf} from ALU, valid with alu_done
- disp_word  out  16  word for the seven-segment driver
- disp_en  out  1  display enable (0 = blank all digits)
- flags  out  3  latched {eq, brw, ovf}
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on multi-button press or ALU timeout

## Operation
- Each btn bit passes through a 2-FF synchronizer and then an independent debouncer. The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles, and the counter restarts on any bounce. A press event is a 0->1 transition of the debounced level.
- FSM states: IDLE, ISSUE, WAIT, SHOW_OP, SHOW_RES.
- IDLE
  - disp_en=0 and busy=0.
  - On any press event, check the full debounced vector. If exactly one bit is high, latch sw_a/sw_b into alu_a/alu_b, set alu_op to the index of the high bit, clear flags, and go to ISSUE. Otherwise pulse err and stay in IDLE.
- ISSUE
  - alu_start=1 for this cycle only.
  - alu_done in this cycle is ignored.
  - Next state is WAIT.
- WAIT
  - On alu_done, capture alu_result into an internal result register and alu_flags into flags, then go to SHOW_OP.
  - If DONE_TIMEOUT cycles elapse in WAIT without alu_done, pulse err, leave flags=0, and go to IDLE.
- SHOW_OP
  - disp_en=1 and disp_word={alu_b, alu_a}.
  - Stays exactly PHASE_CYCLES cycles, then goes to SHOW_RES.
- SHOW_RES
  - disp_en=1 and disp_word=result.
  - Stays exactly PHASE_CYCLES cycles, then goes to IDLE.
- Press events in any state other than IDLE are discarded; there is no queuing.
- A button held through the whole sequence does not retrigger; it must be released and re-pressed.
- flags hold their value after returning to IDLE and are cleared only when the next operation is accepted or on reset.
- The phase counter is clog2(PHASE_CYCLES+1) bits wide, cleared on every state entry, and never wraps.

## Timing
- Reset (asynchronous, effective immediately): state=IDLE; every output is 0 (alu_start, alu_op, alu_a, alu_b, disp_word, disp_en, flags, busy, err); debouncers, synchronizers and counters are 0.
- Reset asserted mid-sequence aborts the sequence with no further alu_start. A debounced button still high after reset release does not produce an event until it has been released and re-pressed.
- All outputs are registered.
- Latency from press to start:
  - Raw press at cycle 0 with no bounce gives a debounced rise at cycle 2+DEBOUNCE_CYCLES.
  - alu_start is high in the following cycle.
- Latency from done to display: alu_done in cycle D gives disp_en=1 with the operand word in D+1.
- Result display begins exactly PHASE_CYCLES cycles after operand display begins. disp_en falls exactly 2*PHASE_CYCLES cycles after it rose.
- If alu_done arrives in the same cycle the timeout expires, done wins.
- A press event and a phase-end in the same cycle: the event is discarded.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, PHASE_CYCLES=8, DONE_TIMEOUT=16; the ALU model responds 2 cycles after start unless stated otherwise.
- Add: sw_a=0x3C, sw_b=0x05, btn=0001 held clean.
  - One alu_start with alu_op=00 and alu_a=0x3C.
  - ALU returns 0x0041 with flags 000.
  - disp_word=0x053C for 8 cycles, then 0x0041 for 8 cycles, then disp_en=0 and busy=0.
- Bounce: btn[1] toggles every 2 cycles for 20 cycles, then stays high.
  - No alu_start during the bounce.
  - Exactly one alu_start with op=01, 7 cycles after the input becomes stable.
- Multi-button: btn=0011 pressed simultaneously.
  - One err pulse; no alu_start; busy stays 0.
- Busy lockout: while in SHOW_OP, press btn[3].
  - No second alu_start.
  - After return to IDLE with btn[3] still held, still no start.
  - Release and re-press gives op=11.
- Timeout: ALU model never asserts done.
  - err pulses exactly 16 cycles after entering WAIT; state returns to IDLE; disp_en stays 0; flags=000.
- Reset mid-operation: assert rst during SHOW_RES.
  - All outputs 0 in the same cycle.
  - After release, no alu_start until btn is released and re-pressed.
